// File: rtl/xadc_drp_pkg.sv
// Shared DRP address map, reset values and state encodings
// for the XADC DRP responder and its initiators.
package xadc_drp_pkg;

  localparam logic [6:0] VAUXP0_ADDR = 7'h10;
  localparam logic [6:0] VAUXP1_ADDR = 7'h11;
  localparam logic [6:0] VAUXP2_ADDR = 7'h12;
  localparam logic [6:0] VAUXP3_ADDR = 7'h13;

  localparam logic [6:0] CFG0_ADDR = 7'h40;
  localparam logic [6:0] CFG1_ADDR = 7'h41;
  localparam logic [6:0] CFG2_ADDR = 7'h42;

  localparam logic [15:0] CFG0_RST = 16'h0000;
  localparam logic [15:0] CFG1_RST = 16'h1000;
  localparam logic [15:0] CFG2_RST = 16'h0400;

  localparam int SEQ_EN_BIT = 12;

  typedef enum logic [1:0] {
    DRP_IDLE,
    DRP_WAIT,
    DRP_RESP
  } drp_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CONV,
    SEQ_GAP
  } seq_state_t;

  function automatic logic [15:0] status_word(
    input logic [11:0] s
  );
    return {s, 4'h0};
  endfunction

endpackage

// File: rtl/xadc_conv_sequencer.sv
// Continuous aux-channel conversion sequencer: CONV/GAP
// loop, channel counter, BUSY/EOC/EOS and result strobe.
module xadc_conv_sequencer
  import xadc_drp_pkg::*;
#(
  parameter int CONV_CYCLES = 26,
  parameter int NUM_CH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seq_en_i,
  output logic       busy_o,
  output logic       eoc_o,
  output logic       eos_o,
  output logic [4:0] channel_o,
  output logic       wr_en_o,
  output logic [1:0] wr_idx_o
);

  localparam int CW = $clog2(CONV_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [1:0] CH_LAST = 2'(NUM_CH - 1);

  seq_state_t      st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      ch_q, ch_d;
  logic [1:0]      last_q, last_d;
  logic            done;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= SEQ_IDLE;
      cnt_q  <= '0;
      ch_q   <= '0;
      last_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      ch_q   <= ch_d;
      last_q <= last_d;
    end
  end

  // seq_en is the registered CFG1 bit, so a conversion ending
  // in the same cycle as a CFG1 write still completes.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    ch_d   = ch_q;
    last_d = last_q;
    done   = 1'b0;
    if (!seq_en_i) begin
      st_d  = SEQ_IDLE;
      cnt_d = '0;
      ch_d  = '0;
    end else begin
      unique case (st_q)
        SEQ_IDLE: begin
          st_d  = SEQ_CONV;
          cnt_d = CNT_LAST;
          ch_d  = '0;
        end
        SEQ_CONV: begin
          if (cnt_q == '0) begin
            done   = 1'b1;
            last_d = ch_q;
            st_d   = SEQ_GAP;
            ch_d   = (ch_q == CH_LAST) ? 2'd0
                                       : ch_q + 2'd1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SEQ_GAP: begin
          st_d  = SEQ_CONV;
          cnt_d = CNT_LAST;
        end
        default: st_d = SEQ_IDLE;
      endcase
    end
  end

  assign busy_o    = (st_q == SEQ_CONV) && seq_en_i;
  assign eoc_o     = done;
  assign eos_o     = done && (ch_q == CH_LAST);
  assign channel_o = {3'b000, done ? ch_q : last_q};
  assign wr_en_o   = done;
  assign wr_idx_o  = ch_q;

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC DRP slave emulation: DRP handshake FSM, status and
// config register file, and the aux conversion sequencer.
module xadc_drp_responder
  import xadc_drp_pkg::*;
#(
  parameter int DRP_LATENCY = 4,
  parameter int CONV_CYCLES = 26,
  parameter int NUM_CH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic        BUSY,
  output logic        EOC,
  output logic        EOS,
  output logic [4:0]  CHANNEL,
  output logic        DRP_ERR,
  input  logic [11:0] AUX_IN0,
  input  logic [11:0] AUX_IN1,
  input  logic [11:0] AUX_IN2,
  input  logic [11:0] AUX_IN3
);

  localparam logic [3:0] LAT_INIT = 4'(DRP_LATENCY - 1);

  drp_state_t  st_q, st_d;
  logic [3:0]  lat_q, lat_d;
  logic [6:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wd_q, wd_d;
  logic [15:0] do_q, do_d;
  logic        err_q, err_d;
  logic [15:0] cfg0_q, cfg0_d;
  logic [15:0] cfg1_q, cfg1_d;
  logic [15:0] cfg2_q, cfg2_d;
  logic [11:0] res_q [4];
  logic [11:0] res_d [4];

  logic        resp;
  logic [15:0] rdata;
  logic [11:0] aux [4];
  logic        wr_en;
  logic [1:0]  wr_idx;

  xadc_conv_sequencer #(
    .CONV_CYCLES (CONV_CYCLES),
    .NUM_CH      (NUM_CH)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .seq_en_i  (cfg1_q[SEQ_EN_BIT]),
    .busy_o    (BUSY),
    .eoc_o     (EOC),
    .eos_o     (EOS),
    .channel_o (CHANNEL),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx)
  );

  assign aux[0] = AUX_IN0;
  assign aux[1] = AUX_IN1;
  assign aux[2] = AUX_IN2;
  assign aux[3] = AUX_IN3;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= DRP_IDLE;
      lat_q  <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      wd_q   <= '0;
      do_q   <= '0;
      err_q  <= 1'b0;
      cfg0_q <= CFG0_RST;
      cfg1_q <= CFG1_RST;
      cfg2_q <= CFG2_RST;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      st_q   <= st_d;
      lat_q  <= lat_d;
      addr_q <= addr_d;
      we_q   <= we_d;
      wd_q   <= wd_d;
      do_q   <= do_d;
      err_q  <= err_d;
      cfg0_q <= cfg0_d;
      cfg1_q <= cfg1_d;
      cfg2_q <= cfg2_d;
      for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
    end
  end

  always_comb begin
    st_d   = st_q;
    lat_d  = lat_q;
    addr_d = addr_q;
    we_d   = we_q;
    wd_d   = wd_q;
    err_d  = err_q | (DEN && (st_q != DRP_IDLE));
    unique case (st_q)
      DRP_IDLE: begin
        if (DEN) begin
          addr_d = DADDR;
          we_d   = DWE;
          wd_d   = DI;
          lat_d  = LAT_INIT;
          st_d   = (DRP_LATENCY == 1) ? DRP_RESP
                                      : DRP_WAIT;
        end
      end
      DRP_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) st_d = DRP_RESP;
      end
      DRP_RESP: st_d = DRP_IDLE;
      default:  st_d = DRP_IDLE;
    endcase
  end

  assign resp = (st_q == DRP_RESP);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr_q == VAUXP0_ADDR:
        rdata = status_word(res_q[0]);
      addr_q == VAUXP1_ADDR:
        if (NUM_CH > 1) rdata = status_word(res_q[1]);
      addr_q == VAUXP2_ADDR:
        if (NUM_CH > 2) rdata = status_word(res_q[2]);
      addr_q == VAUXP3_ADDR:
        if (NUM_CH > 3) rdata = status_word(res_q[3]);
      addr_q == CFG0_ADDR: rdata = cfg0_q;
      addr_q == CFG1_ADDR: rdata = cfg1_q;
      addr_q == CFG2_ADDR: rdata = cfg2_q;
      default: rdata = '0;
    endcase
  end

  // Status registers are read-only; only CFG takes writes.
  always_comb begin
    cfg0_d = cfg0_q;
    cfg1_d = cfg1_q;
    cfg2_d = cfg2_q;
    if (resp && we_q) begin
      unique case (1'b1)
        addr_q == CFG0_ADDR: cfg0_d = wd_q;
        addr_q == CFG1_ADDR: cfg1_d = wd_q;
        addr_q == CFG2_ADDR: cfg2_d = wd_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) res_d[i] = res_q[i];
    if (wr_en) res_d[wr_idx] = aux[wr_idx];
  end

  // Read data is live during RESP, then held until next read.
  assign do_d    = (resp && !we_q) ? rdata : do_q;
  assign DO      = do_d;
  assign DRDY    = resp;
  assign DRP_ERR = err_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Scoreboard bench for xadc_drp_responder: DRP stimulus pushes
// expectations, a negedge monitor pops them on DRDY/EOC.
module tb_xadc_drp_responder;

  localparam int DRP_LAT    = 4;
  localparam int CONV       = 26;
  localparam int NCH        = 4;
  localparam int EOS_PERIOD = NCH * (CONV + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  DADDR = '0;
  logic        DEN = 1'b0;
  logic        DWE = 1'b0;
  logic [15:0] DI = '0;
  logic [15:0] DO;
  logic        DRDY, BUSY, EOC, EOS;
  logic [4:0]  CHANNEL;
  logic        DRP_ERR;
  logic [11:0] AUX_IN0 = 12'h123;
  logic [11:0] AUX_IN1 = 12'h456;
  logic [11:0] AUX_IN2 = 12'h789;
  logic [11:0] AUX_IN3 = 12'hABC;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [15:0] sb_data[$];
  int          sb_due[$];
  bit          sb_rd[$];
  logic [6:0]  sb_addr[$];
  logic [15:0] last_do = '0;

  int ch_epoch = 0;
  int seen_epoch = 0;
  int exp_ch = 0;
  int eoc_cnt = 0;

  xadc_drp_responder #(
    .DRP_LATENCY (DRP_LAT),
    .CONV_CYCLES (CONV),
    .NUM_CH      (NCH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .DADDR   (DADDR),
    .DEN     (DEN),
    .DWE     (DWE),
    .DI      (DI),
    .DO      (DO),
    .DRDY    (DRDY),
    .BUSY    (BUSY),
    .EOC     (EOC),
    .EOS     (EOS),
    .CHANNEL (CHANNEL),
    .DRP_ERR (DRP_ERR),
    .AUX_IN0 (AUX_IN0),
    .AUX_IN1 (AUX_IN1),
    .AUX_IN2 (AUX_IN2),
    .AUX_IN3 (AUX_IN3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  // Monitor: pops DRP expectations and tracks channel order.
  always @(negedge clk) begin
    int         due;
    logic [15:0] d;
    bit         rd;
    logic [6:0] a;
    if (ch_epoch != seen_epoch) begin
      seen_epoch = ch_epoch;
      exp_ch = 0;
    end
    if (DRDY === 1'b1) begin
      if (sb_due.size() == 0) begin
        chk("unexpected_drdy", 32'(DRDY), 32'd0);
      end else begin
        due = sb_due.pop_front();
        d   = sb_data.pop_front();
        rd  = sb_rd.pop_front();
        a   = sb_addr.pop_front();
        chk($sformatf("drdy_latency_%0h", a), cyc, due);
        if (rd) chk($sformatf("read_%0h", a), DO, d);
        else chk($sformatf("write_do_hold_%0h", a), DO, d);
      end
    end else if (sb_due.size() > 0 && cyc > sb_due[0]) begin
      chk($sformatf("missing_drdy_%0h", sb_addr[0]),
          32'd0, 32'd1);
      void'(sb_due.pop_front());
      void'(sb_data.pop_front());
      void'(sb_rd.pop_front());
      void'(sb_addr.pop_front());
    end
    if (EOC === 1'b1) begin
      eoc_cnt++;
      chk("eoc_eos_channel", {EOS, CHANNEL},
          {exp_ch == NCH - 1, 5'(exp_ch)});
      exp_ch = (exp_ch + 1) % NCH;
    end else if (EOS === 1'b1) begin
      chk("eos_without_eoc", 32'(EOS), 32'd0);
    end
  end

  task automatic drp(input logic [6:0] a, input logic we,
                     input logic [15:0] d,
                     input logic [15:0] exp_rd);
    sb_due.push_back(cyc + DRP_LAT);
    sb_rd.push_back(!we);
    sb_addr.push_back(a);
    sb_data.push_back(we ? last_do : exp_rd);
    if (!we) last_do = exp_rd;
    DADDR = a;
    DWE = we;
    DI = d;
    DEN = 1'b1;
    @(posedge clk); #1;
    DEN = 1'b0;
    DWE = 1'b0;
    repeat (DRP_LAT) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ev(input bit want_eos, input int lim,
                         output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (want_eos ? (EOS === 1'b1) : (EOC === 1'b1)) begin
        at = cyc;
        break;
      end
    end
    chk(want_eos ? "wait_eos" : "wait_eoc",
        32'(at >= 0), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, n;

    // reset state
    @(negedge clk);
    chk("reset_outputs",
        {DO, DRDY, BUSY, EOC, EOS, CHANNEL, DRP_ERR}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: full sequence then read all results
    wait_ev(1'b1, 300, t);
    drp(7'h10, 1'b0, 16'h0, 16'h1230);
    drp(7'h11, 1'b0, 16'h0, 16'h4560);
    drp(7'h12, 1'b0, 16'h0, 16'h7890);
    drp(7'h13, 1'b0, 16'h0, 16'hABC0);

    // 2: unmapped read, read-only write, CFG access
    drp(7'h05, 1'b0, 16'h0, 16'h0000);
    drp(7'h10, 1'b1, 16'hFFFF, 16'h0);
    drp(7'h10, 1'b0, 16'h0, 16'h1230);
    drp(7'h40, 1'b1, 16'hBEEF, 16'h0);
    drp(7'h40, 1'b0, 16'h0, 16'hBEEF);
    drp(7'h42, 1'b0, 16'h0, 16'h0400);

    // 3: sequencer disable mid-conversion and restart
    wait_ev(1'b0, 100, t);
    drp(7'h41, 1'b1, 16'h0000, 16'h0);
    chk("busy_after_seq_off", 32'(BUSY), 32'd0);
    ch_epoch++;
    n = eoc_cnt;
    repeat (60) begin @(posedge clk); #1; end
    chk("eoc_while_off", eoc_cnt - n, 32'd0);
    chk("busy_while_off", 32'(BUSY), 32'd0);
    drp(7'h41, 1'b0, 16'h0, 16'h0000);
    drp(7'h41, 1'b1, 16'h1000, 16'h0);
    wait_ev(1'b0, 100, t);
    chk("channel_after_reenable", 32'(CHANNEL), 32'd0);

    // 4: overlapping DEN sets sticky error
    chk("drp_err_clean", 32'(DRP_ERR), 32'd0);
    sb_due.push_back(cyc + DRP_LAT);
    sb_rd.push_back(1'b1);
    sb_addr.push_back(7'h41);
    sb_data.push_back(16'h1000);
    last_do = 16'h1000;
    DADDR = 7'h41; DWE = 1'b0; DEN = 1'b1;
    @(posedge clk); #1;
    DEN = 1'b0;
    @(posedge clk); #1;
    DADDR = 7'h40; DWE = 1'b1; DI = 16'hDEAD; DEN = 1'b1;
    @(posedge clk); #1;
    DEN = 1'b0; DWE = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("drp_err_set", 32'(DRP_ERR), 32'd1);
    drp(7'h40, 1'b0, 16'h0, 16'hBEEF);
    drp(7'h42, 1'b0, 16'h0, 16'h0400);
    chk("drp_err_sticky", 32'(DRP_ERR), 32'd1);

    // 5: read RESP colliding with ch3 result write
    wait_ev(1'b1, 300, t);
    AUX_IN3 = 12'h5A5;
    while (cyc < t + EOS_PERIOD - DRP_LAT) begin
      @(posedge clk); #1;
    end
    drp(7'h13, 1'b0, 16'h0, 16'hABC0);
    drp(7'h13, 1'b0, 16'h0, 16'h5A50);

    // 6: reset during WAIT drops the transaction
    DADDR = 7'h41; DWE = 1'b0; DEN = 1'b1;
    @(posedge clk); #1;
    DEN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ch_epoch++;
    last_do = '0;
    @(negedge clk);
    chk("reset_outputs_mid_wait",
        {DO, DRDY, BUSY, EOC, EOS, CHANNEL, DRP_ERR}, 32'd0);
    @(posedge clk); #1;
    repeat (8) begin @(posedge clk); #1; end
    drp(7'h41, 1'b0, 16'h0, 16'h1000);
    drp(7'h40, 1'b0, 16'h0, 16'h0000);
    wait_ev(1'b1, 300, t1);
    wait_ev(1'b1, 300, t2);
    chk("eos_period", t2 - t1, EOS_PERIOD);

    repeat (2) begin @(posedge clk); #1; end
    chk("scoreboard_drained", sb_due.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
